rd_stream_framer: RTL and testbench
===================================

# rd_stream_framer

Read-domain consumer of the async FIFO. It pops bytes through the FIFO read port, which has one cycle of read latency, and prefetches them into a small buffer. It emits them as framed packets on a valid/ready stream: sync byte, length byte, PKT_LEN payload bytes, then an XOR checksum. It runs entirely in the 65 MHz read domain, directly downstream of the FIFO.

## Interface
- DATA_WIDTH, 8, byte width; must equal the FIFO DATA_WIDTH.
- PKT_LEN, 4, payload bytes per frame; range 1..255.
- SYNC_BYTE, 8'hA5, first beat of every frame.
- rd_clk  in  1  read-domain clock. One clock; all logic on its rising edge.
- rd_rst_n  in  1  reset, asynchronous, active-low.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data. Valid the cycle after fifo_rd_en is sampled high.
- fifo_empty  in  1  FIFO empty flag.
- out_data  out  DATA_WIDTH  stream beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink ready.
- out_sof  out  1  high on the SYNC beat.
- out_last  out  1  high on the checksum beat.
- pkt_count  out  16  frames completed.
- busy  out  1  high when the FSM is not in IDLE.

## Operation
- Prefetch buffer, 3 entries:
  - fifo_rd_en = !fifo_empty && (occupancy + in_flight) < 3.
  - in_flight is 1 for the cycle after a pop.
  - Captured data is written into the buffer on the next edge.
  - fifo_rd_en is never high while fifo_empty is high.
- FSM states and transitions (each transition happens on a beat handshake, out_valid && out_ready):
  - IDLE → SYNC when the buffer is non-empty. No header is sent without at least one payload byte in hand.
  - SYNC → LEN.
  - LEN → PAY.
  - PAY → CSUM after PKT_LEN payload beats.
  - CSUM → IDLE.
- Beat contents:
  - SYNC: SYNC_BYTE.
  - LEN: PKT_LEN[7:0].
  - PAY: buffer head, popped on handshake.
  - CSUM: XOR of the LEN byte and all payload bytes.
- Checksum accumulator: reset to PKT_LEN on SYNC; XORs each payload byte on its handshake.
- Starvation in PAY: when the buffer is empty, out_valid is low and the FSM stays in PAY. The payload counter holds; there is no timeout.
- Output register:
  - Loads a new beat only when !out_valid || out_ready.
  - While out_valid && !out_ready, out_data, out_sof and out_last are held stable.
- pkt_count increments on the CSUM handshake and wraps from 16'hFFFF to 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_sof 0, out_last 0, fifo_rd_en 0, pkt_count 0, busy 0. FSM in IDLE; buffer and accumulator cleared.
- Reset mid-frame: the partial frame, the buffered bytes and any in-flight byte are discarded. No checksum is emitted.
- Latency, from fifo_rd_en sampled at edge E0:
  - Data is captured into the buffer at E1.
  - The SYNC beat is valid after E2.
- Throughput: with out_ready held high and the FIFO non-empty, a frame is PKT_LEN+3 beats on consecutive cycles.
- Back-to-back frames: the SYNC of frame N+1 follows the CSUM of frame N on the next cycle when the buffer is non-empty.
- Simultaneous events in one cycle:
  - Buffer push and pop: occupancy is unchanged.
  - Credit check: uses registered occupancy.

## Structure
- Package rd_framer_pkg holds:
  - the state enum (IDLE, SYNC, LEN, PAY, CSUM);
  - the SYNC_BYTE default;
  - the prefetch depth constant (3).
- Sub-module rd_prefetch_buf: a 3-entry FIFO with the credit/in-flight logic. It owns fifo_rd_en.
- The top holds the FSM, payload counter, checksum and output register.

## Test plan
- Basic frame: PKT_LEN=4; write 10,20,30,40 into the FIFO; out_ready=1.
  - Beats: A5, 04, 10, 20, 30, 40, 44.
  - out_sof on A5, out_last on 44, pkt_count=1.
- Back-to-back: write A0..A7.
  - Two frames, each with checksum 04, with no idle cycle between them.
  - pkt_count=2.
- Backpressure: drop out_ready for 5 cycles during PAY.
  - out_data is held stable throughout.
  - At most 3 bytes are prefetched.
  - Beat order is intact after release.
- Starvation: write 50,51, then 52,53 after 20 cycles.
  - out_valid is low during the gap.
  - Frame completes with checksum 04.
  - fifo_rd_en is never high while fifo_empty is high.
- Reset mid-frame: assert rd_rst_n low after the LEN beat.
  - All outputs return to their reset values immediately.
  - After release, the next written bytes C0..C3 produce a clean frame with checksum 04.
- Count: stream 3 frames, then assert reset.
  - pkt_count reads 3 before the reset and 0 after it.

Source files
------------

// File: rtl/rd_framer_pkg.sv
// Shared types and constants for the read-domain stream framer.
package rd_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN,
        PAY,
        CSUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         PF_DEPTH      = 3;

endpackage

// File: rtl/rd_prefetch_buf.sv
// Three-entry prefetch buffer in front of the async FIFO read port.
// Issues pops on credit (occupancy plus the one-cycle read in flight).
module rd_prefetch_buf
    import rd_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  not_empty
);

    logic [DATA_WIDTH-1:0] mem [PF_DEPTH];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [1:0]            occ;
    logic                  in_flight;
    logic                  run;
    logic                  push;
    logic                  pop_ok;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(PF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // run keeps pops off while reset is held and for the release edge
    assign fifo_rd_en = run && !fifo_empty &&
                        (({1'b0, occ} + {2'b00, in_flight}) < 3'(PF_DEPTH));
    assign push       = in_flight;
    assign pop_ok     = pop && not_empty;
    assign head       = mem[rd_ptr];
    assign not_empty  = (occ != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            in_flight <= 1'b0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            occ       <= 2'd0;
            for (int i = 0; i < PF_DEPTH; i++) mem[i] <= '0;
        end else begin
            run       <= 1'b1;
            in_flight <= fifo_rd_en;
            if (push) begin
                mem[wr_ptr] <= fifo_rd_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop_ok})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/rd_stream_framer.sv
// Frames prefetched FIFO bytes as SYNC, LEN, PKT_LEN payload bytes, XOR checksum
// on a valid/ready stream. The state names the beat held in the output register.
module rd_stream_framer
    import rd_framer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 4,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(SYNC_BYTE_DEF)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_last,
    output logic [15:0]           pkt_count,
    output logic                  busy
);

    localparam logic [7:0]            LEN8     = 8'(PKT_LEN);
    localparam logic [DATA_WIDTH-1:0] LEN_BYTE = DATA_WIDTH'(LEN8);

    state_t                state, state_nxt;
    logic [7:0]            pay_cnt, pay_cnt_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  valid_nxt, sof_nxt, last_nxt;
    logic [15:0]           pkt_count_nxt;
    logic                  load;
    logic                  buf_pop;
    logic                  buf_ne;
    logic [DATA_WIDTH-1:0] buf_head;

    rd_prefetch_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk          (rd_clk),
        .rst_n        (rd_rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .pop          (buf_pop),
        .head         (buf_head),
        .not_empty    (buf_ne)
    );

    assign load = !out_valid || out_ready;
    assign busy = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        pay_cnt_nxt   = pay_cnt;
        acc_nxt       = acc;
        data_nxt      = out_data;
        valid_nxt     = out_valid;
        sof_nxt       = out_sof;
        last_nxt      = out_last;
        pkt_count_nxt = pkt_count;
        buf_pop       = 1'b0;
        if (load) begin
            valid_nxt = 1'b0;
            sof_nxt   = 1'b0;
            last_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    // a header only goes out once a payload byte is in hand
                    if (buf_ne) begin
                        state_nxt   = SYNC;
                        valid_nxt   = 1'b1;
                        sof_nxt     = 1'b1;
                        data_nxt    = SYNC_BYTE;
                        acc_nxt     = LEN_BYTE;
                        pay_cnt_nxt = 8'd0;
                    end
                end
                SYNC: begin
                    state_nxt = LEN;
                    valid_nxt = 1'b1;
                    data_nxt  = LEN_BYTE;
                end
                LEN, PAY: begin
                    if (state == PAY && pay_cnt == LEN8) begin
                        state_nxt = CSUM;
                        valid_nxt = 1'b1;
                        last_nxt  = 1'b1;
                        data_nxt  = acc;
                    end else begin
                        // starved payload: drop valid and hold the count
                        state_nxt = PAY;
                        if (buf_ne) begin
                            buf_pop     = 1'b1;
                            valid_nxt   = 1'b1;
                            data_nxt    = buf_head;
                            acc_nxt     = acc ^ buf_head;
                            pay_cnt_nxt = pay_cnt + 8'd1;
                        end
                    end
                end
                CSUM: begin
                    pkt_count_nxt = pkt_count + 16'd1;
                    if (buf_ne) begin
                        state_nxt   = SYNC;
                        valid_nxt   = 1'b1;
                        sof_nxt     = 1'b1;
                        data_nxt    = SYNC_BYTE;
                        acc_nxt     = LEN_BYTE;
                        pay_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state     <= IDLE;
            pay_cnt   <= 8'd0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
            pkt_count <= 16'd0;
        end else begin
            state     <= state_nxt;
            pay_cnt   <= pay_cnt_nxt;
            acc       <= acc_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            out_sof   <= sof_nxt;
            out_last  <= last_nxt;
            pkt_count <= pkt_count_nxt;
        end
    end

endmodule

// File: tb/tb_rd_stream_framer.sv
// Bench for rd_stream_framer: FIFO model, beat monitor, frame-level reference model.
module tb_rd_stream_framer;

    localparam int PKT_LEN = 4;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_empty;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_last;
    logic [15:0] pkt_count;
    logic        busy;

    rd_stream_framer #(.DATA_WIDTH(8), .PKT_LEN(PKT_LEN)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_last     (out_last),
        .pkt_count    (pkt_count),
        .busy         (busy)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct { logic [9:0] beat; int cyc; } beat_t;
    typedef struct { logic [31:0] pay; logic [7:0] csum; } vec_t;

    // FIFO model: written by the stimulus, read by the clocked model
    logic [7:0] wmem [4096];
    int         wr_idx = 0;
    int         rd_idx = 0;
    assign fifo_empty = (wr_idx == rd_idx);

    beat_t gmem [4096];
    int    got_w = 0;
    int    got_r = 0;
    int    cyc = 0;
    int    pops = 0;
    int    hs_pay = 0;
    int    underflow = 0;
    logic  prev_sof = 1'b0;

    always @(posedge rd_clk) begin
        cyc = cyc + 1;
        if (out_valid && out_ready) begin
            gmem[got_w].beat = {out_sof, out_last, out_data};
            gmem[got_w].cyc  = cyc;
            got_w = got_w + 1;
            if (!out_sof && !out_last && !prev_sof) hs_pay = hs_pay + 1;
            prev_sof = out_sof;
        end
        if (fifo_rd_en) begin
            if (fifo_empty) underflow = underflow + 1;
            else begin
                fifo_rd_data <= wmem[rd_idx];
                rd_idx       <= rd_idx + 1;
                pops = pops + 1;
            end
        end
    end

    int         checks = 0;
    int         failures = 0;
    logic [9:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge rd_clk);
    endtask

    task automatic push(input logic [7:0] b);
        wmem[wr_idx] = b;
        wr_idx++;
    endtask

    task automatic push_word(input logic [31:0] w);
        @(negedge rd_clk);
        for (int k = 0; k < 4; k++) push(w[31-8*k -: 8]);
    endtask

    // Reference model: frame = SYNC, LEN, payload, XOR(LEN, payload)
    task automatic model_frame(input logic [31:0] w);
        logic [7:0] cs;
        cs = 8'(PKT_LEN);
        exp_q.push_back({2'b10, 8'hA5});
        exp_q.push_back({2'b00, 8'(PKT_LEN)});
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({2'b00, w[31-8*k -: 8]});
            cs = cs ^ w[31-8*k -: 8];
        end
        exp_q.push_back({2'b01, cs});
    endtask

    task automatic exp_lit(input logic [31:0] w, input logic [7:0] cs);
        exp_q.push_back({2'b10, 8'hA5});
        exp_q.push_back({2'b00, 8'h04});
        for (int k = 0; k < 4; k++) exp_q.push_back({2'b00, w[31-8*k -: 8]});
        exp_q.push_back({2'b01, cs});
    endtask

    task automatic wait_beats(input string name, input int n);
        int t;
        t = 0;
        while ((got_w - got_r) < n && t < 400) begin
            @(negedge rd_clk);
            t++;
        end
        if ((got_w - got_r) < n) chk({name, "_timeout"}, 32'(got_w - got_r), 32'(n));
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((got_w - got_r) < exp_q.size() && t < 4000) begin
            @(negedge rd_clk);
            t++;
        end
        if ((got_w - got_r) < exp_q.size())
            chk({name, "_timeout"}, 32'(got_w - got_r), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_r < got_w) begin
            chk(name, 32'(gmem[got_r].beat), 32'(exp_q.pop_front()));
            got_r++;
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input string name);
        @(negedge rd_clk);
        rd_rst_n = 1'b0;
        #1;
        chk({name, "_ctl"}, 32'({out_valid, out_sof, out_last, busy, fifo_rd_en}), 32'd0);
        chk({name, "_data"}, 32'(out_data), 32'd0);
        chk({name, "_pkt_count"}, 32'(pkt_count), 32'd0);
        tick(2);
        rd_rst_n = 1'b1;
        got_r = got_w;
        exp_q.delete();
        tick(2);
    endtask

    vec_t       tv [6];
    logic [7:0] rb [160];
    int         b;
    int         viol;

    initial begin
        tv[0] = '{32'h10203040, 8'h44};
        tv[1] = '{32'hA0A1A2A3, 8'h04};
        tv[2] = '{32'hA4A5A6A7, 8'h04};
        tv[3] = '{32'hFF00FF00, 8'h04};
        tv[4] = '{32'h01020408, 8'h0B};
        tv[5] = '{32'h00000000, 8'h04};

        rd_rst_n  = 1'b0;
        out_ready = 1'b1;
        tick(2);
        chk("init_ctl", 32'({out_valid, out_sof, out_last, busy, fifo_rd_en}), 32'd0);
        chk("init_data", 32'(out_data), 32'd0);
        chk("init_pkt_count", 32'(pkt_count), 32'd0);
        rd_rst_n = 1'b1;
        tick(2);

        // first-frame latency and throughput
        push_word(32'h11223344);
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1 chk("lat_e1_valid", 32'(out_valid), 32'd0);
        @(posedge rd_clk);
        #1 chk("lat_e2_sync", 32'({out_valid, out_sof, out_data}), 32'({2'b11, 8'hA5}));
        b = got_r;
        model_frame(32'h11223344);
        drain("latency");
        chk("lat_throughput", 32'(gmem[b+6].cyc - gmem[b].cyc), 32'd6);
        chk("pkt_count_a", 32'(pkt_count), 32'd1);

        for (int i = 0; i < 6; i++) begin
            push_word(tv[i].pay);
            exp_lit(tv[i].pay, tv[i].csum);
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_pkt_count", i), 32'(pkt_count), 32'(i + 2));
        end

        // back-to-back frames
        b = got_r;
        push_word(32'hA0A1A2A3);
        push_word(32'hA4A5A6A7);
        exp_lit(32'hA0A1A2A3, 8'h04);
        exp_lit(32'hA4A5A6A7, 8'h04);
        drain("b2b");
        chk("b2b_gap", 32'(gmem[b+7].cyc - gmem[b+6].cyc), 32'd1);
        chk("b2b_span", 32'(gmem[b+13].cyc - gmem[b].cyc), 32'd13);
        chk("b2b_pkt_count", 32'(pkt_count), 32'd9);

        // backpressure in PAY
        b = pops - hs_pay;
        push_word(32'hB0B1B2B3);
        push_word(32'hB4B5B6B7);
        wait_beats("bp_start", 3);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge rd_clk);
            chk("bp_hold", 32'({out_valid, out_sof, out_last, out_data}), 32'({3'b100, 8'hB1}));
        end
        chk("bp_prefetch", 32'(pops - hs_pay - b), 32'd4);
        out_ready = 1'b1;
        model_frame(32'hB0B1B2B3);
        model_frame(32'hB4B5B6B7);
        drain("bp");
        chk("bp_pkt_count", 32'(pkt_count), 32'd11);

        // starvation mid-payload
        @(negedge rd_clk);
        push(8'h50);
        push(8'h51);
        wait_beats("starve_start", 4);
        viol = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge rd_clk);
            if (out_valid) viol++;
        end
        chk("starve_valid_low", 32'(viol), 32'd0);
        chk("starve_busy", 32'(busy), 32'd1);
        push(8'h52);
        push(8'h53);
        exp_lit(32'h50515253, 8'h04);
        drain("starve");
        chk("starve_pkt_count", 32'(pkt_count), 32'd12);

        // reset after the LEN beat
        @(negedge rd_clk);
        push(8'hD0);
        push(8'hD1);
        push(8'hD2);
        wait_beats("midrst_start", 2);
        do_reset("midrst");
        push_word(32'hC0C1C2C3);
        exp_lit(32'hC0C1C2C3, 8'h04);
        drain("after_rst");
        chk("after_rst_pkt_count", 32'(pkt_count), 32'd1);

        // three frames then reset
        do_reset("cnt_pre");
        for (int f = 0; f < 3; f++) begin
            logic [31:0] w;
            w = $urandom;
            model_frame(w);
            push_word(w);
        end
        drain("cnt");
        chk("cnt_pkt_count_3", 32'(pkt_count), 32'd3);
        do_reset("cnt_post");

        // random bytes, random gaps, random backpressure
        for (int i = 0; i < 160; i++) rb[i] = 8'($urandom);
        for (int f = 0; f < 40; f++)
            model_frame({rb[4*f], rb[4*f+1], rb[4*f+2], rb[4*f+3]});
        begin
            int idx;
            idx = 0;
            while (idx < 160) begin
                @(negedge rd_clk);
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) != 0) begin
                    push(rb[idx]);
                    idx++;
                end
            end
        end
        @(negedge rd_clk);
        out_ready = 1'b1;
        drain("rand");
        chk("rand_pkt_count", 32'(pkt_count), 32'd40);
        chk("no_pop_when_empty", 32'(underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
